// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for a single-bus datapath. Sequences the
// fetch (T0-T2), decode (T3) and execute/writeback (T4-T5) steps of one
// instruction, and parks in HALTED or FAULT until reset.
//
// Ports
//   Clock, Reset_n        : clock, asynchronous active-low reset
//   Run                   : start/continue request (sampled in IDLE and at
//                           the last step of an instruction)
//   Mem_Ready             : memory read data valid this cycle
//   IR_Data[31:0]         : instruction register contents
//                           opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15]
//   PC_Out/ZLO_Out/MDR_Out: bus-drive selects
//   MAR_In/PC_In/MDR_In/IR_In/Y_In/Z_In : register load enables
//   IncPC, Read           : PC increment and memory read strobes
//   CONTROL[4:0]          : ALU operation code
//   R_Out[15:0], R_In[15:0] : one-hot general register drive / load
//   Busy, Halted, Fault, Illegal : status flags
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter int READ_TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Run,
    input  logic        Mem_Ready,
    input  logic [31:0] IR_Data,
    output logic        PC_Out,
    output logic        ZLO_Out,
    output logic        MDR_Out,
    output logic        MAR_In,
    output logic        PC_In,
    output logic        MDR_In,
    output logic        IR_In,
    output logic        Y_In,
    output logic        Z_In,
    output logic        IncPC,
    output logic        Read,
    output logic [4:0]  CONTROL,
    output logic [15:0] R_Out,
    output logic [15:0] R_In,
    output logic        Busy,
    output logic        Halted,
    output logic        Fault,
    output logic        Illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALTED, S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        OP_ALU, OP_NOP, OP_HALT, OP_ILLEGAL
    } op_class_t;

    localparam int CNT_W = (READ_TIMEOUT > 0) ? $clog2(READ_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(READ_TIMEOUT);

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;

    logic [4:0] w_opcode;
    logic [3:0] w_ra, w_rb, w_rc;
    op_class_t  w_class;
    logic       w_unused_ir_bits;

    assign w_opcode = IR_Data[31:27];
    assign w_ra     = IR_Data[26:23];
    assign w_rb     = IR_Data[22:19];
    assign w_rc     = IR_Data[18:15];
    // Immediate/unused instruction bits are not needed by the sequencer.
    assign w_unused_ir_bits = ^IR_Data[14:0];

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_class = OP_ILLEGAL;
        unique case (w_opcode)
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
            5'b00101, 5'b00110, 5'b00111, 5'b01000: w_class = OP_ALU;
            5'b11010:                               w_class = OP_NOP;
            5'b11100:                               w_class = OP_HALT;
            default:                                w_class = OP_ILLEGAL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: if (Run) r_state <= S_T0;
                S_T0: begin
                    r_state    <= S_T1;
                    r_wait_cnt <= '0;    // T0 is the only way into T1
                end
                S_T1: begin
                    // Data arriving on the last allowed cycle still wins.
                    if (Mem_Ready)                     r_state <= S_T2;
                    else if (r_wait_cnt == TIMEOUT_VAL) r_state <= S_FAULT;
                    else r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                end
                S_T2: r_state <= S_T3;
                S_T3: begin
                    unique case (w_class)
                        OP_ALU:  r_state <= S_T4;
                        OP_HALT: r_state <= S_HALTED;
                        default: r_state <= Run ? S_T0 : S_IDLE;
                    endcase
                end
                S_T4:     r_state <= S_T5;
                S_T5:     r_state <= Run ? S_T0 : S_IDLE;
                S_HALTED: r_state <= S_HALTED;
                S_FAULT:  r_state <= S_FAULT;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are a combinational decode of the state register: the T3-T5
    // enables depend on IR_Data, which only holds the new instruction after
    // the T2 edge, so they cannot be registered a cycle early. Reset forces
    // the state to IDLE asynchronously, which drives every output to 0.
    always_comb begin
        PC_Out  = 1'b0;
        ZLO_Out = 1'b0;
        MDR_Out = 1'b0;
        MAR_In  = 1'b0;
        PC_In   = 1'b0;
        MDR_In  = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        Z_In    = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        CONTROL = 5'b00000;
        R_Out   = 16'h0000;
        R_In    = 16'h0000;
        Busy    = 1'b0;
        Halted  = 1'b0;
        Fault   = 1'b0;
        Illegal = 1'b0;
        unique case (r_state)
            S_T0: begin
                Busy   = 1'b1;
                PC_Out = 1'b1;
                MAR_In = 1'b1;
                IncPC  = 1'b1;
                Z_In   = 1'b1;
            end
            S_T1: begin
                Busy    = 1'b1;
                ZLO_Out = 1'b1;
                PC_In   = 1'b1;
                Read    = 1'b1;
                MDR_In  = 1'b1;
            end
            S_T2: begin
                Busy    = 1'b1;
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
            end
            S_T3: begin
                Busy = 1'b1;
                if (w_class == OP_ALU) begin
                    R_Out = 16'h0001 << w_rb;
                    Y_In  = 1'b1;
                end
                Illegal = (w_class == OP_ILLEGAL);
            end
            S_T4: begin
                Busy    = 1'b1;
                R_Out   = 16'h0001 << w_rc;
                CONTROL = w_opcode;
                Z_In    = 1'b1;
            end
            S_T5: begin
                Busy    = 1'b1;
                ZLO_Out = 1'b1;
                R_In    = 16'h0001 << w_ra;
            end
            S_HALTED: Halted = 1'b1;
            S_FAULT:  Fault  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//
// Scoreboard bench. The stimulus process walks whole instructions described
// at the instruction level (opcode, registers, memory wait length, Run at
// the end) and pushes the expected output vector of every cycle into a
// queue; a monitor on the falling edge pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    localparam int TIMEOUT = 15;

    logic        Clock     = 1'b0;
    logic        Reset_n   = 1'b0;
    logic        Run       = 1'b0;
    logic        Mem_Ready = 1'b0;
    logic [31:0] IR_Data   = '0;

    logic        PC_Out, ZLO_Out, MDR_Out;
    logic        MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In;
    logic        IncPC, Read;
    logic [4:0]  CONTROL;
    logic [15:0] R_Out, R_In;
    logic        Busy, Halted, Fault, Illegal;

    typedef struct packed {
        logic        pc_out, zlo_out, mdr_out;
        logic        mar_in, pc_in, mdr_in, ir_in, y_in, z_in;
        logic        inc_pc, read;
        logic [4:0]  control;
        logic [15:0] r_out, r_in;
        logic        busy, halted, fault, illegal;
    } outs_t;

    outs_t act;
    assign act = {PC_Out, ZLO_Out, MDR_Out, MAR_In, PC_In, MDR_In, IR_In,
                  Y_In, Z_In, IncPC, Read, CONTROL, R_Out, R_In,
                  Busy, Halted, Fault, Illegal};

    outs_t exp_q[$];
    string tag_q[$];
    bit    mon_en  = 1'b0;
    int    n_total = 0;
    int    n_bad   = 0;

    control_sequencer #(.READ_TIMEOUT(TIMEOUT)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Run       (Run),
        .Mem_Ready (Mem_Ready),
        .IR_Data   (IR_Data),
        .PC_Out    (PC_Out),
        .ZLO_Out   (ZLO_Out),
        .MDR_Out   (MDR_Out),
        .MAR_In    (MAR_In),
        .PC_In     (PC_In),
        .MDR_In    (MDR_In),
        .IR_In     (IR_In),
        .Y_In      (Y_In),
        .Z_In      (Z_In),
        .IncPC     (IncPC),
        .Read      (Read),
        .CONTROL   (CONTROL),
        .R_Out     (R_Out),
        .R_In      (R_In),
        .Busy      (Busy),
        .Halted    (Halted),
        .Fault     (Fault),
        .Illegal   (Illegal)
    );

    always #5 Clock = ~Clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: bus exclusivity every cycle, scoreboard compare when enabled.
    always @(negedge Clock) begin
        outs_t e;
        string t;
        check("bus_single_driver",
              64'($countones({PC_Out, ZLO_Out, MDR_Out, R_Out}) <= 1), 64'd1);
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL sb_underflow: DUT cycle with no expected entry");
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, 64'(act), 64'(e));
            end
        end
    end

    // ---------------- reference model: per-step expectations ----------------
    function automatic bit rand_bit();
        return 1'($urandom);
    endfunction

    // 0 = ALU, 1 = nop, 2 = halt, 3 = illegal
    function automatic int op_kind(input logic [4:0] op);
        if (op <= 5'd8)  return 0;
        if (op == 5'd26) return 1;
        if (op == 5'd28) return 2;
        return 3;
    endfunction

    function automatic outs_t e_fetch_addr();
        outs_t e = '0;
        e.busy = 1'b1; e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.z_in = 1'b1;
        return e;
    endfunction

    function automatic outs_t e_fetch_wait();
        outs_t e = '0;
        e.busy = 1'b1; e.zlo_out = 1'b1; e.pc_in = 1'b1; e.read = 1'b1; e.mdr_in = 1'b1;
        return e;
    endfunction

    function automatic outs_t e_exec_t4(input logic [4:0] op, input int rc);
        outs_t e = '0;
        e.busy = 1'b1; e.r_out = 16'd1 << rc; e.control = op; e.z_in = 1'b1;
        return e;
    endfunction

    // One clock cycle: apply inputs, queue the expected outputs, advance.
    task automatic cyc(input bit run, input bit mr, input logic [31:0] ir,
                       input outs_t e, input string tag);
        Run       = run;
        Mem_Ready = mr;
        IR_Data   = ir;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge Clock);
        #1;
    endtask

    // Called at posedge+1. Asserts reset between edges, checks outputs drop
    // at once, holds it, releases mid-cycle with Run=1 and expects the
    // sequencer to stay idle until the next rising edge, then start at T0.
    task automatic reset_pulse(input string tag);
        mon_en = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        check({tag, "_async_clear"}, 64'(act), 64'd0);
        Run       = 1'b1;
        Mem_Ready = rand_bit();
        IR_Data   = $urandom;
        repeat (2) begin
            @(posedge Clock);
            #1;
            check({tag, "_held"}, 64'(act), 64'd0);
        end
        #2;
        Reset_n = 1'b1;
        #1;
        check({tag, "_no_edge_yet"}, 64'(act), 64'd0);
        exp_q.push_back('0);
        tag_q.push_back({tag, "_idle"});
        mon_en = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_then_go(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, rand_bit(), $urandom, '0, "idle");
        cyc(1'b1, rand_bit(), $urandom, '0, "idle_run");
    endtask

    // Runs one instruction starting in T0.
    task automatic run_instr(input logic [31:0] ir, input int waits,
                             input bit run_end, input bit abort_t4);
        logic [4:0] op;
        int ra, rb, rc;
        outs_t e;
        op = ir[31:27];
        ra = int'(ir[26:23]);
        rb = int'(ir[22:19]);
        rc = int'(ir[18:15]);

        cyc(rand_bit(), rand_bit(), ir, e_fetch_addr(), "T0");
        for (int i = 0; i < waits; i++) cyc(rand_bit(), 1'b0, ir, e_fetch_wait(), "T1_wait");
        cyc(rand_bit(), 1'b1, ir, e_fetch_wait(), "T1_ready");
        e = '0; e.busy = 1'b1; e.mdr_out = 1'b1; e.ir_in = 1'b1;
        cyc(rand_bit(), rand_bit(), ir, e, "T2");

        e = '0; e.busy = 1'b1;
        case (op_kind(op))
            0: begin
                e.r_out = 16'd1 << rb; e.y_in = 1'b1;
                cyc(rand_bit(), rand_bit(), ir, e, "T3_alu");
                if (abort_t4) begin
                    check("T4_before_reset", 64'(act), 64'(e_exec_t4(op, rc)));
                    reset_pulse("mid_T4");
                    return;
                end
                cyc(rand_bit(), rand_bit(), ir, e_exec_t4(op, rc), "T4");
                e = '0; e.busy = 1'b1; e.zlo_out = 1'b1; e.r_in = 16'd1 << ra;
                cyc(run_end, rand_bit(), ir, e, "T5");
            end
            1: cyc(run_end, rand_bit(), ir, e, "T3_nop");
            2: cyc(rand_bit(), rand_bit(), ir, e, "T3_halt");
            default: begin
                e.illegal = 1'b1;
                cyc(run_end, rand_bit(), ir, e, "T3_illegal");
            end
        endcase
    endtask

    // ------------------------------- stimulus -------------------------------
    initial begin
        outs_t e;
        @(posedge Clock);
        #1;
        check("por_outputs_zero", 64'(act), 64'd0);
        reset_pulse("por");

        // add R5,R2,R4
        run_instr(32'h0292_0000, 0, 1'b1, 1'b0);
        // memory slow for three cycles
        run_instr({5'd1, 4'd7, 4'd9, 4'd11, 15'd0}, 3, 1'b1, 1'b0);
        // Ra = Rb = Rc
        run_instr({5'd0, 4'd3, 4'd3, 4'd3, 15'h1234}, 0, 1'b1, 1'b0);
        // illegal, continue / stop
        run_instr(32'hF800_0000, 0, 1'b1, 1'b0);
        run_instr(32'hF800_0000, 1, 1'b0, 1'b0);
        idle_then_go(2);
        // nop then stop
        run_instr(32'hD000_0000, 0, 1'b0, 1'b0);
        idle_then_go(0);
        // longest wait that still succeeds
        run_instr({5'd8, 4'd15, 4'd0, 4'd14, 15'd0}, TIMEOUT, 1'b1, 1'b0);

        for (int n = 0; n < 150; n++) begin
            logic [4:0] op;
            int r, waits;
            bit run_end;
            r = int'($urandom_range(0, 9));
            if (r < 6)      op = 5'($urandom_range(0, 8));
            else if (r < 8) op = 5'd26;
            else begin
                op = 5'($urandom);
                while (op_kind(op) != 3) op = 5'($urandom);
            end
            waits   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT))
                                                  : int'($urandom_range(0, 2));
            run_end = ($urandom_range(0, 3) != 0);
            run_instr({op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)},
                      waits, run_end, 1'b0);
            if (!run_end) idle_then_go(int'($urandom_range(0, 3)));
        end

        // reset in the middle of T4
        run_instr({5'd2, 4'd1, 4'd6, 4'd12, 15'd0}, 0, 1'b1, 1'b1);

        // halt: sticky regardless of Run
        run_instr(32'hE000_0000, 0, 1'b1, 1'b0);
        e = '0; e.halted = 1'b1;
        for (int i = 0; i < 8; i++) cyc(rand_bit(), rand_bit(), $urandom, e, "halted_hold");
        reset_pulse("halt_exit");

        // memory never answers: TIMEOUT+1 T1 cycles, then fault
        cyc(1'b1, rand_bit(), 32'h0292_0000, e_fetch_addr(), "T0_fault_run");
        for (int i = 0; i <= TIMEOUT; i++)
            cyc(rand_bit(), 1'b0, 32'h0292_0000, e_fetch_wait(), "T1_timeout");
        e = '0; e.fault = 1'b1;
        for (int i = 0; i < 6; i++) cyc(rand_bit(), rand_bit(), $urandom, e, "fault_hold");
        reset_pulse("fault_exit");

        mon_en = 1'b0;
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter READ_TIMEOUT, default 15, SHALL set the maximum T1 wait cycles for Mem_Ready before a fault is declared.
REQ-002 Clock  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 Reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 Run  in  1  SHALL request instruction execution; it is sampled in IDLE and at the end of T5.
REQ-005 Mem_Ready  in  1  SHALL indicate memory read data is valid on the MDR input this cycle.
REQ-006 IR_Data  in  32  SHALL carry the datapath IR output: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
REQ-007 PC_Out, ZLO_Out, MDR_Out  out  1 each  SHALL be the datapath bus-drive selects.
REQ-008 MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In  out  1 each  SHALL be the datapath register load enables.
REQ-009 IncPC, Read  out  1 each  SHALL be the PC-increment and memory-read strobes.
REQ-010 CONTROL  out  5  SHALL be the ALU operation code.
REQ-011 R_Out, R_In  out  16 each  SHALL be the one-hot general-register drive and load enables.
REQ-012 Busy, Halted, Fault, Illegal  out  1 each  SHALL be the status flags.

Function
REQ-013 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, HALTED, FAULT; outputs SHALL be a Moore decode of state plus IR_Data fields.
REQ-014 IDLE: all outputs 0; Run=1 -> T0, else stay.
REQ-015 T0: PC_Out, MAR_In, IncPC, Z_In = 1; -> T1.
REQ-016 T1: ZLO_Out, PC_In, Read, MDR_In = 1; Mem_Ready=1 -> T2, else stay and increment the wait counter.
REQ-017 Wait counter SHALL clear on T1 entry; Mem_Ready=0 when counter = READ_TIMEOUT -> FAULT (Fault=1, all other outputs 0, held until reset).
REQ-018 IncPC SHALL assert only in T0, never repeated during T1 waits.
REQ-019 T2: MDR_Out, IR_In = 1; -> T3.
REQ-020 T3 decodes IR_Data[31:27]: ALU ops 00000 add, 00001 sub, 00010 and, 00011 or, 00100 shr, 00101 shra, 00110 shl, 00111 ror, 01000 rol; 11010 nop; 11100 halt; all others illegal.
REQ-021 T3, ALU op: R_Out bit Rb = 1, Y_In = 1; -> T4.
REQ-022 T3, nop: no enables; -> T0 if Run=1, else IDLE.
REQ-023 T3, halt: no enables; -> HALTED (Halted=1, held until reset).
REQ-024 T3, illegal: Illegal = 1 for that cycle only, no enables; next state as for nop.
REQ-025 T4: R_Out bit Rc = 1, CONTROL = opcode, Z_In = 1; CONTROL SHALL be 00000 in every other state.
REQ-026 T5: ZLO_Out = 1, R_In bit Ra = 1; -> T0 if Run=1, else IDLE.
REQ-027 At most one of PC_Out, ZLO_Out, MDR_Out and R_Out bits SHALL be 1 in any cycle.
REQ-028 Busy SHALL be 1 in T0-T5 and 0 in IDLE, HALTED and FAULT.
REQ-029 Ra = Rb = Rc (e.g. add R3,R3,R3) SHALL sequence normally; R_In and R_Out bits may coincide across cycles.

Reset
REQ-030 Reset_n = 0 SHALL force IDLE, clear the wait counter and drive every output to 0 asynchronously, including mid-instruction and in HALTED or FAULT.
REQ-031 After Reset_n deasserts, the first state change SHALL occur on a rising Clock edge.

Verification
REQ-032 Run=1, Mem_Ready=1, IR_Data=0x02920000 (add R5,R2,R4) -> T0..T5 in 6 cycles; T3 R_Out=0x0004; T4 R_Out=0x0010, CONTROL=00000; T5 R_In=0x0020; then T0.
REQ-033 Mem_Ready low for 3 T1 cycles, then high -> T1 held 4 cycles; Read and MDR_In high throughout; IncPC high in T0 only.
REQ-034 Mem_Ready held 0 -> FAULT after READ_TIMEOUT+1 T1 cycles (16 at default); Fault=1, Busy=0 until Reset_n=0.
REQ-035 IR_Data=0xE0000000 -> HALTED after T3, Halted=1; Run toggling has no effect.
REQ-036 IR_Data=0xF8000000 -> Illegal=1 for exactly the T3 cycle, no enables, then T0; with Run=0 at T3 -> IDLE.
REQ-037 Reset_n=0 asserted mid-T4 (between edges) -> all outputs 0 before the next edge; state IDLE.
